avalon_led_blink_pio: RTL and testbench
=======================================

Name: avalon_led_blink_pio

Overview:
Parametrised Avalon-MM slave output port that drives a bank of LEDs (or any output bits).
- Adds atomic bit set/clear registers and a per-bit hardware blink mode with a programmable half-period counter.
- Lets software flash status LEDs without CPU polling.
- Sits on the system interconnect beside the other PIO slaves; `out_port` goes to board pins.

Parameters:
- WIDTH, 8, number of output bits (1..32)
- CNT_W, 24, width of blink half-period register and counter (1..32)
- RESET_VALUE, 0, reset value of the DATA register (WIDTH bits)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  word register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data
- readdata  output  32  read data, zero-extended, combinational from address
- out_port  output  WIDTH  LED drive

Behaviour:
- Clock and reset: clk is the clock. reset_n is asynchronous, active-low.
- Reset values:
  - DATA = RESET_VALUE; BLINK = 0; HALF_PERIOD = 0.
  - cnt = 0; phase = 0.
  - out_port = RESET_VALUE; readdata follows address (DATA at addr 0).
- Write condition: write occurs on a rising clk with chipselect=1 and write_n=0. Unused upper writedata bits are ignored.
- Register map:
  - 0 DATA, RW: full write of writedata[WIDTH-1:0].
  - 1 BLINK, RW: per-bit blink enable mask.
  - 2 HALF_PERIOD, RW: writedata[CNT_W-1:0]. A write also forces cnt=0 and phase=0 on the same edge.
  - 3 STATUS, RO: bit0 = phase; other bits 0. Writes ignored.
  - 4 OUTSET, WO: DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
  - 5 OUTCLR, WO: DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
  - 6, 7: reserved. Reads return 0; writes ignored.
- Read path:
  - Zero wait states: readdata is valid the same cycle address is presented, independent of chipselect.
  - Register bits above WIDTH/CNT_W read as 0.
- Blink timer:
  - HALF_PERIOD = 0: timer disabled; cnt held 0, phase held 0.
  - Otherwise, each clk: if cnt == HALF_PERIOD-1, then cnt <= 0 and phase toggles; else cnt <= cnt+1.
  - Resulting phase period = 2*HALF_PERIOD clocks. HALF_PERIOD=1 toggles phase every clock.
  - HALF_PERIOD write has priority over the counter update in the same cycle.
- Output:
  - out_port[i] = DATA[i] & (~BLINK[i] | phase). This is combinational from registers.
  - Non-blinking bits follow DATA. Blinking bits show DATA gated by phase, so they are off while phase=0.
  - Write-to-pin latency: 1 clk (visible after the write edge).
- Simultaneous events:
  - Only one register is written per cycle (single address), so no set/clear conflict exists.
  - A DATA/OUTSET/OUTCLR write during blinking does not disturb cnt or phase.
- Reset mid-operation: all registers, cnt and phase return to reset values immediately (asynchronous). Operation restarts from phase 0 after release.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5; reads of addr 0/1/2/3 return 32'hA5/0/0/0.
- Write DATA=32'hFFFF_FF3C (WIDTH=8), then read addr 0 -> readdata=32'h3C, out_port=8'h3C one clk after the write edge.
- From DATA=8'h3C: OUTSET 8'h81 -> DATA=8'hBD; OUTCLR 8'h0C -> DATA=8'hB1; reads of addr 4/5 return 0.
- DATA=8'hFF, BLINK=8'h0F, HALF_PERIOD=4:
  - out_port=8'hF0 for 4 clks, then 8'hFF for 4 clks, repeating.
  - STATUS bit0 toggles every 4 clks.
- Mid-blink, rewrite HALF_PERIOD=2 -> phase=0 and cnt=0 on that edge; toggles then occur every 2 clks. Writing HALF_PERIOD=0 -> phase stuck at 0 and blinking bits stay off.
- Assert reset_n low asynchronously between clock edges while phase=1 -> out_port=RESET_VALUE and STATUS=0 immediately. After release, with HALF_PERIOD=0, no blinking occurs.

Source files
------------

// File: rtl/avalon_led_blink_pio.sv
// Avalon-MM LED output port with atomic set/clear and per-bit hardware blink.
// Zero-wait-state reads; blink phase toggles every HALF_PERIOD clocks.
module avalon_led_blink_pio #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       CNT_W       = 24,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_HALF   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_q, blink_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    logic             wr;
    logic [WIDTH-1:0] wd_w;
    logic [CNT_W-1:0] wd_c;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_w      = writedata[WIDTH-1:0];
    assign wd_c      = writedata[CNT_W-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d  = data_q;
        blink_d = blink_q;
        half_d  = half_q;
        if (wr) begin
            case (address)
                A_DATA:   data_d  = wd_w;
                A_BLINK:  blink_d = wd_w;
                A_HALF:   half_d  = wd_c;
                A_OUTSET: data_d  = data_q | wd_w;
                A_OUTCLR: data_d  = data_q & ~wd_w;
                default:  ;
            endcase
        end
    end

    // A HALF_PERIOD write restarts the timer and wins over the count.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && address == A_HALF) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == half_q - CNT_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            blink_q <= '0;
            half_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            blink_q <= blink_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0] = data_q;
            A_BLINK:  readdata[WIDTH-1:0] = blink_q;
            A_HALF:   readdata[CNT_W-1:0] = half_q;
            A_STATUS: readdata[0]         = phase_q;
            default:  ;
        endcase
    end

    assign out_port = data_q & (~blink_q | {WIDTH{phase_q}});

endmodule

// File: tb/tb_avalon_led_blink_pio.sv
// Bench for avalon_led_blink_pio: expected values are queued when
// stimulus is driven and popped when the DUT output is sampled.
module tb_avalon_led_blink_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic [31:0] exp;

    avalon_led_blink_pio #(
        .WIDTH(8),
        .CNT_W(24),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] tbl [8] = '{32'hA5, 0, 0, 0, 0, 0, 0, 0};
        reset_n = 1'b0;
        #12;
        sb.push_back(32'hA5);
        exp = sb.pop_front(); checks++;
        if (out_port !== exp[7:0]) begin
            failures++;
            $display("FAIL reset_out got=%h want=%h", out_port, exp[7:0]);
        end
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            sb.push_back(tbl[i]);
            #1;
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL reset_rd%0d got=%h want=%h", i, readdata, exp);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_data_write();
        bus_write(3'd0, 32'hFFFF_FF3C);
        sb.push_back(32'h3C);
        sb.push_back(32'h3C);
        address = 3'd0;
        #1;
        exp = sb.pop_front(); checks++;
        if (out_port !== exp[7:0]) begin
            failures++;
            $display("FAIL data_out got=%h want=%h", out_port, exp[7:0]);
        end
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL data_rd got=%h want=%h", readdata, exp);
        end
    endtask

    task automatic test_set_clr();
        logic [2:0]  wa [4] = '{3'd4, 3'd5, 3'd3, 3'd7};
        logic [31:0] wv [4] = '{32'hFFFF_FF81, 32'h0C, 32'hFF, 32'hFF};
        logic [7:0]  ev [4] = '{8'hBD, 8'hB1, 8'hB1, 8'hB1};
        for (int i = 0; i < 4; i++) begin
            bus_write(wa[i], wv[i]);
            sb.push_back({24'h0, ev[i]});
            sb.push_back(32'h0);
            sb.push_back({24'h0, ev[i]});
            #1;
            exp = sb.pop_front(); checks++;
            if (out_port !== exp[7:0]) begin
                failures++;
                $display("FAIL setclr_out%0d got=%h want=%h",
                         i, out_port, exp[7:0]);
            end
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL setclr_rd_wo%0d got=%h want=%h",
                         i, readdata, exp);
            end
            address = 3'd0;
            #1;
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL setclr_rd0_%0d got=%h want=%h",
                         i, readdata, exp);
            end
        end
    endtask

    task automatic test_blink();
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'hFFFF_FF0F);
        address = 3'd1;
        sb.push_back(32'h0F);
        #1;
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL blink_rd got=%h want=%h", readdata, exp);
        end
        bus_write(3'd2, 32'hFF00_0004);
        address = 3'd2;
        sb.push_back(32'h4);
        #1;
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL half_rd got=%h want=%h", readdata, exp);
        end
        address = 3'd3;
        for (int k = 0; k < 16; k++) begin
            sb.push_back(((k / 4) % 2) ? 32'hFF : 32'hF0);
            sb.push_back(32'((k / 4) % 2));
            #1;
            exp = sb.pop_front(); checks++;
            if (out_port !== exp[7:0]) begin
                failures++;
                $display("FAIL blink_out k=%0d got=%h want=%h",
                         k, out_port, exp[7:0]);
            end
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL blink_status k=%0d got=%h want=%h",
                         k, readdata, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_half_rewrite();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        address = 3'd3;
        sb.push_back(32'h1);
        #1;
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL pre_rewrite_phase got=%h want=%h", readdata, exp);
        end
        bus_write(3'd2, 32'h2);
        address = 3'd3;
        for (int j = 0; j < 8; j++) begin
            sb.push_back(((j / 2) % 2) ? 32'hFF : 32'hF0);
            sb.push_back(32'((j / 2) % 2));
            #1;
            exp = sb.pop_front(); checks++;
            if (out_port !== exp[7:0]) begin
                failures++;
                $display("FAIL hp2_out j=%0d got=%h want=%h",
                         j, out_port, exp[7:0]);
            end
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL hp2_status j=%0d got=%h want=%h",
                         j, readdata, exp);
            end
            @(posedge clk);
            #1;
        end
        bus_write(3'd2, 32'h0);
        address = 3'd3;
        for (int j = 0; j < 6; j++) begin
            sb.push_back(32'hF0);
            sb.push_back(32'h0);
            #1;
            exp = sb.pop_front(); checks++;
            if (out_port !== exp[7:0]) begin
                failures++;
                $display("FAIL hp0_out j=%0d got=%h want=%h",
                         j, out_port, exp[7:0]);
            end
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL hp0_status j=%0d got=%h want=%h",
                         j, readdata, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        bus_write(3'd2, 32'h1);
        @(posedge clk);
        #1;
        address = 3'd3;
        sb.push_back(32'h1);
        sb.push_back(32'hFF);
        #1;
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL prereset_phase got=%h want=%h", readdata, exp);
        end
        exp = sb.pop_front(); checks++;
        if (out_port !== exp[7:0]) begin
            failures++;
            $display("FAIL prereset_out got=%h want=%h", out_port, exp[7:0]);
        end
        #1;
        reset_n = 1'b0;
        sb.push_back(32'hA5);
        sb.push_back(32'h0);
        #1;
        exp = sb.pop_front(); checks++;
        if (out_port !== exp[7:0]) begin
            failures++;
            $display("FAIL arst_out got=%h want=%h", out_port, exp[7:0]);
        end
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL arst_status got=%h want=%h", readdata, exp);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            sb.push_back(32'hA5);
            sb.push_back(32'h0);
            exp = sb.pop_front(); checks++;
            if (out_port !== exp[7:0]) begin
                failures++;
                $display("FAIL postrst_out j=%0d got=%h want=%h",
                         j, out_port, exp[7:0]);
            end
            exp = sb.pop_front(); checks++;
            if (readdata !== exp) begin
                failures++;
                $display("FAIL postrst_status j=%0d got=%h want=%h",
                         j, readdata, exp);
            end
        end
        address = 3'd2;
        sb.push_back(32'h0);
        #1;
        exp = sb.pop_front(); checks++;
        if (readdata !== exp) begin
            failures++;
            $display("FAIL postrst_half got=%h want=%h", readdata, exp);
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_set_clr();
        test_blink();
        test_half_rewrite();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
